calc_moment_acc: RTL and testbench
==================================

CALC_MOMENT_ACC -- requirements
Module: calc_moment_acc

Interface
REQ-001 SHALL have parameter PIX_W, default 8: binary pixels per input word; power of 2, 4..32.
REQ-002 SHALL have parameter HCNT_W, default 11: width of the column coordinate.
REQ-003 SHALL have parameter VCNT_W, default 11: width of the row coordinate.
REQ-004 SHALL have parameter ACC_W, default 32: width of each moment accumulator and result.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame abort and clear.
- in_valid  in  1  idata, hcount and vcount are valid this cycle.
- idata  in  PIX_W  idata[PIX_W-1] is the pixel at hcount; idata[0] is the pixel at hcount+PIX_W-1.
- hcount  in  HCNT_W  column of idata[PIX_W-1].
- vcount  in  VCNT_W  row of the current word.
- frame_end  in  1  one-cycle pulse marking the last word of the frame.
- m00  out  ACC_W  set-pixel count.
- m10  out  ACC_W  sum of x over set pixels.
- m01  out  ACC_W  sum of y over set pixels.
- out_valid  out  1  one-cycle result strobe.
- busy  out  1  high in ACCUM and FLUSH.
- ovf  out  1  sticky saturation flag.

Function
REQ-006 SHALL implement the FSM IDLE->ACCUM on in_valid; IDLE->FLUSH on frame_end; ACCUM->FLUSH on frame_end; FLUSH->DONE after PIPE_LAT cycles; DONE->IDLE unconditionally.
REQ-007 PIPE_LAT SHALL equal log2(PIX_W)+2: one input register, log2(PIX_W) adder-tree stages and one accumulate stage.
REQ-008 Accumulators SHALL clear on the IDLE->ACCUM or IDLE->FLUSH transition, and the first word SHALL be included.
REQ-009 For each accepted word, the per-word partials SHALL be: x sum = sum of (hcount+k) over set bits, at index k counted from the MSB; count = popcount; y sum = vcount*popcount.
REQ-010 Per-word partials SHALL be computed at full width, with no truncation of hcount+k.
REQ-011 A word with in_valid and frame_end in the same cycle SHALL be included.
REQ-012 in_valid SHALL be ignored in FLUSH, DONE and IDLE-after-DONE until the next transition to ACCUM.
REQ-013 In DONE, m00, m10 and m01 SHALL load the accumulators and out_valid SHALL be 1 for exactly one cycle.
REQ-014 With frame_end sampled at edge N, out_valid SHALL be high in cycle N+PIPE_LAT+1.
REQ-015 Result outputs SHALL hold until the next DONE, clr or rst.
REQ-016 An accumulator whose sum exceeds 2^ACC_W-1 SHALL saturate at all-ones and set ovf.
REQ-017 ovf SHALL clear only on the IDLE->ACCUM/FLUSH transition, clr or rst.
REQ-018 clr SHALL have priority over all other inputs: FSM to IDLE, accumulators, pipeline, results and ovf to 0, and no out_valid.
REQ-019 An empty frame (frame_end in IDLE) SHALL report all-zero results with out_valid.

Reset
REQ-020 rst SHALL asynchronously force FSM=IDLE, all pipeline registers=0, m00=m10=m01=0, out_valid=0, busy=0 and ovf=0.
REQ-021 rst asserted mid-frame SHALL abort the frame, and no out_valid SHALL follow for that frame.

Configuration
REQ-022 With macro CALC_M01_EN defined, the m01 datapath and accumulator SHALL be built and behave per REQ-009/013/016.
REQ-023 Without CALC_M01_EN, m01 SHALL be constant 0, no y-datapath logic SHALL exist, and the m01 accumulator SHALL never contribute to ovf.

Verification (PIX_W=8, PIPE_LAT=5)
REQ-024 Scenario: rst; idata=8'hFF, hcount=0, vcount=3, with frame_end -> m00=8, m10=28, m01=24, out_valid at N+6 for exactly one cycle.
REQ-025 Scenario: 8'h81 at hcount=16 then 8'h01 at hcount=24, frame_end on the second word -> m00=3, m10=70.
REQ-026 Scenario: ACC_W=12; 8'hFF at hcount=2040, repeated twice -> m10=4095, ovf=1; next frame -> ovf=0.
REQ-027 Scenario: clr two words into a frame -> no out_valid, outputs 0; following frame of 8'h01 at hcount=5 -> m10=12, m00=1.
REQ-028 Scenario: frame_end in IDLE with no data -> out_valid at N+6 with m00=m10=m01=0; rst during FLUSH -> no out_valid.
REQ-029 Scenario: build without CALC_M01_EN, scenario REQ-024 -> m01=0, with m00 and m10 unchanged.

Source files
------------

// File: rtl/calc_moment_acc.sv
// calc_moment_acc -- binary-image moment accumulator.
//
// Accumulates, over one frame of packed binary pixels, the set-pixel count
// (m00), the sum of column coordinates (m10) and, when built with the macro
// CALC_M01_EN, the sum of row coordinates (m01). Each input word is reduced
// by a registered adder tree and added into saturating accumulators; the
// totals are published with a one-cycle out_valid strobe after the frame.
//
// Optional feature: define CALC_M01_EN to build the y (m01) datapath.
// Without it m01 is tied to 0 and vcount is not used.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous abort/clear, highest priority
//   in_valid   idata/hcount/vcount valid this cycle
//   idata      PIX_W pixels, MSB at column hcount, LSB at hcount+PIX_W-1
//   hcount     column of idata[PIX_W-1]
//   vcount     row of the current word
//   frame_end  pulse marking the last word of the frame
//   m00/m10/m01 registered results (held until next result, clr or rst)
//   out_valid  one-cycle result strobe
//   busy       high while accumulating or flushing
//   ovf        sticky saturation flag for the current frame
//
// Handshake: a word is taken on a rising edge where in_valid is high and the
// FSM is IDLE or ACCUM; there is no backpressure. Results are valid only in
// the cycle where out_valid is high and then hold.
module calc_moment_acc #(
    parameter int PIX_W  = 8,
    parameter int HCNT_W = 11,
    parameter int VCNT_W = 11,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  idata,
    input  logic [HCNT_W-1:0] hcount,
    input  logic [VCNT_W-1:0] vcount,
    input  logic              frame_end,
    output logic [ACC_W-1:0]  m00,
    output logic [ACC_W-1:0]  m10,
    output logic [ACC_W-1:0]  m01,
    output logic              out_valid,
    output logic              busy,
    output logic              ovf
);
    localparam int LOG_W    = $clog2(PIX_W);
    localparam int PIPE_LAT = LOG_W + 2;
    localparam int FC_W     = $clog2(PIPE_LAT);
    localparam int CNT_W    = LOG_W + 1;
    // Tree sums of PIX_W terms, each up to (2^HCNT_W-1)+(PIX_W-1).
    localparam int XT_W     = HCNT_W + LOG_W + 1;
    localparam int YT_W     = VCNT_W + LOG_W + 1;
    localparam int WA_W     = (ACC_W > XT_W) ? ACC_W : XT_W;
    localparam int WB_W     = (WA_W > YT_W) ? WA_W : YT_W;
    localparam int SUM_W    = WB_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              start, accept;

    // Saturating add; returns {overflow, value}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        if (s > SUM_W'({ACC_W{1'b1}}))
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // ---------------- FSM ----------------
    assign start  = (state_q == S_IDLE) && (in_valid || frame_end);
    assign accept = in_valid && ((state_q == S_IDLE) || (state_q == S_ACCUM));

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            S_IDLE: begin
                // frame_end wins so a single-word frame goes straight to FLUSH.
                if (frame_end) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end else if (in_valid) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (frame_end) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                end
            end
            S_FLUSH: begin
                if (fcnt_q == FC_W'(PIPE_LAT - 1)) state_d = S_DONE;
                else fcnt_d = fcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
        end
    end

    // ---------------- input register ----------------
    logic              in_v_q, in_v_d;
    logic [PIX_W-1:0]  idata_q, idata_d;
    logic [HCNT_W-1:0] hcount_q, hcount_d;

    always_comb begin
        in_v_d   = accept;
        idata_d  = accept ? idata : idata_q;
        hcount_d = accept ? hcount : hcount_q;
        if (clr) begin
            in_v_d   = 1'b0;
            idata_d  = '0;
            hcount_d = '0;
        end
    end

    // ---------------- adder tree ----------------
    // Heap layout: node i sums children 2i and 2i+1; indices PIX_W..2*PIX_W-1
    // are the combinational leaves, 1..PIX_W-1 are registered, so each tree
    // level adds one cycle and node 1 is the per-word total.
    logic [XT_W-1:0]  nx  [2:2*PIX_W-1];
    logic [CNT_W-1:0] nc  [2:2*PIX_W-1];
    logic [XT_W-1:0]  x_q [1:PIX_W-1];
    logic [XT_W-1:0]  x_d [1:PIX_W-1];
    logic [CNT_W-1:0] c_q [1:PIX_W-1];
    logic [CNT_W-1:0] c_d [1:PIX_W-1];
    logic [LOG_W-1:0] tv_q, tv_d;

    always_comb begin
        for (int k = 0; k < PIX_W; k++) begin
            nx[PIX_W+k] = idata_q[PIX_W-1-k] ? XT_W'(hcount_q) + XT_W'(k) : '0;
            nc[PIX_W+k] = CNT_W'(idata_q[PIX_W-1-k]);
        end
        for (int i = 2; i < PIX_W; i++) begin
            nx[i] = x_q[i];
            nc[i] = c_q[i];
        end
        for (int i = 1; i < PIX_W; i++) begin
            x_d[i] = clr ? '0 : nx[2*i] + nx[2*i+1];
            c_d[i] = clr ? '0 : nc[2*i] + nc[2*i+1];
        end
        tv_d = clr ? '0 : {tv_q[LOG_W-2:0], in_v_q};
    end

    // ---------------- accumulators and results ----------------
    logic              root_v;
    logic [ACC_W-1:0]  acc_x_q, acc_x_d, acc_c_q, acc_c_d;
    logic [ACC_W:0]    sum_x, sum_c;
    logic [ACC_W-1:0]  m00_q, m00_d, m10_q, m10_d;
    logic              ovf_q, ovf_d, out_valid_q, out_valid_d, busy_q, busy_d;

    assign root_v = tv_q[LOG_W-1];
    assign sum_x  = sat_add(acc_x_q, SUM_W'(x_q[1]));
    assign sum_c  = sat_add(acc_c_q, SUM_W'(c_q[1]));

`ifdef CALC_M01_EN
    logic [VCNT_W-1:0] vcount_q, vcount_d;
    logic [YT_W-1:0]   ny  [2:2*PIX_W-1];
    logic [YT_W-1:0]   y_q [1:PIX_W-1];
    logic [YT_W-1:0]   y_d [1:PIX_W-1];
    logic [ACC_W-1:0]  acc_y_q, acc_y_d, m01_q, m01_d;
    logic [ACC_W:0]    sum_y;

    assign sum_y = sat_add(acc_y_q, SUM_W'(y_q[1]));

    // y partial = vcount * popcount, built as a sum of vcount per set bit.
    always_comb begin
        vcount_d = clr ? '0 : (accept ? vcount : vcount_q);
        for (int k = 0; k < PIX_W; k++)
            ny[PIX_W+k] = idata_q[PIX_W-1-k] ? YT_W'(vcount_q) : '0;
        for (int i = 2; i < PIX_W; i++)
            ny[i] = y_q[i];
        for (int i = 1; i < PIX_W; i++)
            y_d[i] = clr ? '0 : ny[2*i] + ny[2*i+1];
        acc_y_d = acc_y_q;
        m01_d   = (state_q == S_DONE) ? acc_y_q : m01_q;
        if (start) acc_y_d = '0;
        else if (root_v) acc_y_d = sum_y[ACC_W-1:0];
        if (clr) begin
            acc_y_d = '0;
            m01_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vcount_q <= '0;
            acc_y_q  <= '0;
            m01_q    <= '0;
            for (int i = 1; i < PIX_W; i++) y_q[i] <= '0;
        end else begin
            vcount_q <= vcount_d;
            acc_y_q  <= acc_y_d;
            m01_q    <= m01_d;
            for (int i = 1; i < PIX_W; i++) y_q[i] <= y_d[i];
        end
    end

    assign m01 = m01_q;
    wire y_ovf = !start && root_v && sum_y[ACC_W];
`else
    logic unused_vcount;
    assign unused_vcount = ^vcount;
    assign m01 = '0;
    wire y_ovf = 1'b0;
`endif

    always_comb begin
        acc_x_d     = acc_x_q;
        acc_c_d     = acc_c_q;
        ovf_d       = ovf_q;
        if (start) begin
            acc_x_d = '0;
            acc_c_d = '0;
            ovf_d   = 1'b0;
        end else if (root_v) begin
            acc_x_d = sum_x[ACC_W-1:0];
            acc_c_d = sum_c[ACC_W-1:0];
            ovf_d   = ovf_q | sum_x[ACC_W] | sum_c[ACC_W] | y_ovf;
        end
        out_valid_d = (state_q == S_DONE);
        m00_d       = (state_q == S_DONE) ? acc_c_q : m00_q;
        m10_d       = (state_q == S_DONE) ? acc_x_q : m10_q;
        busy_d      = (state_d == S_ACCUM) || (state_d == S_FLUSH);
        if (clr) begin
            acc_x_d     = '0;
            acc_c_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            m00_d       = '0;
            m10_d       = '0;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fcnt_q      <= '0;
            in_v_q      <= 1'b0;
            idata_q     <= '0;
            hcount_q    <= '0;
            tv_q        <= '0;
            acc_x_q     <= '0;
            acc_c_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            m00_q       <= '0;
            m10_q       <= '0;
            for (int i = 1; i < PIX_W; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            in_v_q      <= in_v_d;
            idata_q     <= idata_d;
            hcount_q    <= hcount_d;
            tv_q        <= tv_d;
            acc_x_q     <= acc_x_d;
            acc_c_q     <= acc_c_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            m00_q       <= m00_d;
            m10_q       <= m10_d;
            for (int i = 1; i < PIX_W; i++) begin
                x_q[i] <= x_d[i];
                c_q[i] <= c_d[i];
            end
        end
    end

    assign m00       = m00_q;
    assign m10       = m10_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_calc_moment_acc.sv
// Directed bench for calc_moment_acc: a 32-bit accumulator instance for the
// main scenarios and a 12-bit one (shared stimulus) for saturation.
module tb_calc_moment_acc;
    localparam int PIPE_LAT = 5;
`ifdef CALC_M01_EN
    localparam bit M01_ON = 1'b1;
`else
    localparam bit M01_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, frame_end;
    logic [7:0]  idata;
    logic [10:0] hcount, vcount;
    logic [31:0] m00, m10, m01;
    logic        out_valid, busy, ovf;
    logic [11:0] s_m00, s_m10, s_m01;
    logic        s_out_valid, s_busy, s_ovf;

    int n_pass  = 0;
    int n_total = 0;
    int seen;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    calc_moment_acc dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .idata(idata),
        .hcount(hcount), .vcount(vcount), .frame_end(frame_end),
        .m00(m00), .m10(m10), .m01(m01), .out_valid(out_valid),
        .busy(busy), .ovf(ovf)
    );

    calc_moment_acc #(.ACC_W(12)) dut_s (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .idata(idata),
        .hcount(hcount), .vcount(vcount), .frame_end(frame_end),
        .m00(s_m00), .m10(s_m10), .m01(s_m01), .out_valid(s_out_valid),
        .busy(s_busy), .ovf(s_ovf)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        frame_end = 1'b0;
        clr       = 1'b0;
        idata     = '0;
        hcount    = '0;
        vcount    = '0;
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] h, input logic [10:0] v,
                        input bit fe);
        in_valid  = 1'b1;
        idata     = d;
        hcount    = h;
        vcount    = v;
        frame_end = fe;
        tick();
        idle_inputs();
    endtask

    // Called right after the frame_end edge N. Follows edges N+1..N+7 and
    // checks the strobe position, busy and the published results. With junk
    // set, in_valid stays high through FLUSH and DONE and must be ignored.
    task automatic flush_check(input string tag, input logic [31:0] e00,
                               input logic [31:0] e10, input logic [31:0] e01,
                               input bit junk);
        for (int k = 1; k <= PIPE_LAT + 2; k++) begin
            if (junk && k <= PIPE_LAT + 1) begin
                in_valid = 1'b1;
                idata    = 8'hFF;
                hcount   = 11'd100;
                vcount   = 11'd9;
            end else begin
                idle_inputs();
            end
            tick();
            check({tag, "_out_valid"}, out_valid, k == PIPE_LAT + 1);
            check({tag, "_busy"}, busy, k < PIPE_LAT);
            if (k == PIPE_LAT + 1) begin
                check({tag, "_m00"}, m00, e00);
                check({tag, "_m10"}, m10, e10);
                check({tag, "_m01"}, m01, e01);
            end
        end
        check({tag, "_m10_hold"}, m10, e10);
        idle_inputs();
    endtask

    task automatic quiet_window(input string tag);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check({tag, "_no_out_valid"}, seen, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_m00", m00, 0);
        check("rst_m10", m10, 0);
        check("rst_m01", m01, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        // Full word at column 0, row 3.
        send(8'hFF, 11'd0, 11'd3, 1'b1);
        flush_check("full_word", 8, 28, M01_ON ? 32'd24 : 32'd0, 1'b0);

        // Two words; pixels at 16, 23 and 31.
        send(8'h81, 11'd16, 11'd0, 1'b0);
        check("two_word_busy", busy, 1);
        send(8'h01, 11'd24, 11'd0, 1'b1);
        flush_check("two_word", 3, 70, 0, 1'b0);

        // Words offered during FLUSH and DONE are dropped.
        send(8'hFF, 11'd0, 11'd2, 1'b1);
        flush_check("ignore_flush", 8, 28, M01_ON ? 32'd16 : 32'd0, 1'b1);

        // Saturation: 2 x (8*2040+28) = 32696 exceeds 4095 on the 12-bit unit.
        send(8'hFF, 11'd2040, 11'd0, 1'b0);
        send(8'hFF, 11'd2040, 11'd0, 1'b1);
        flush_check("big", 16, 32696, 0, 1'b0);
        check("big_ovf_wide", ovf, 0);
        check("sat_m10", s_m10, 4095);
        check("sat_m00", s_m00, 16);
        check("sat_ovf", s_ovf, 1);
        send(8'h01, 11'd5, 11'd0, 1'b1);
        check("sat_ovf_cleared", s_ovf, 0);
        flush_check("after_sat", 1, 12, 0, 1'b0);
        check("after_sat_m10", s_m10, 12);
        check("after_sat_ovf", s_ovf, 0);

        // Load distinct results, then abort a frame with clr.
        send(8'hFF, 11'd0, 11'd3, 1'b1);
        flush_check("pre_clr", 8, 28, M01_ON ? 32'd24 : 32'd0, 1'b0);
        send(8'hFF, 11'd0, 11'd1, 1'b0);
        send(8'hFF, 11'd8, 11'd1, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_m00", m00, 0);
        check("clr_m10", m10, 0);
        check("clr_m01", m01, 0);
        check("clr_busy", busy, 0);
        check("clr_ovf", ovf, 0);
        quiet_window("clr");
        send(8'h01, 11'd5, 11'd0, 1'b1);
        flush_check("post_clr", 1, 12, 0, 1'b0);

        // Empty frame.
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        flush_check("empty", 0, 0, 0, 1'b0);

        // Reset while flushing aborts the frame.
        send(8'hFF, 11'd0, 11'd3, 1'b1);
        flush_check("pre_rst", 8, 28, M01_ON ? 32'd24 : 32'd0, 1'b0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        check("flush_rst_m00", m00, 0);
        check("flush_rst_m10", m10, 0);
        check("flush_rst_busy", busy, 0);
        quiet_window("flush_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
